// File: rtl/uart_frame_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default frame
// geometry (bit duration in system clocks, data bits per frame) used by both
// the receive and transmit paths.
package uart_frame_receiver_pkg;

  // 12 MHz system clock / 115200 baud.
  localparam int DEFAULT_BIT_DURATION  = 104;
  localparam int DEFAULT_NUM_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Receiver bus bundle: serial line in, received word out with valid/ack
// handshake, plus error and status flags.
//   master : the receiver (drives data/status, reads rx_in and rx_ack)
//   slave  : the line driver / consumer side
interface uart_frame_receiver_if
  import uart_frame_receiver_pkg::*;
#(
  parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS
);
  logic                     rx_in;
  logic                     rx_ack;
  logic [NUM_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_frame_err;
  logic                     rx_overrun;
  logic                     rx_busy;

  modport master (
    input  rx_in, rx_ack,
    output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
  );

  modport slave (
    output rx_in, rx_ack,
    input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_frame_receiver_sync.sv
// Multi-stage flop synchronizer for an asynchronous single-bit input.
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (STAGES clocks of latency)
// Flops reset to RESET_VAL so an idle-high line does not look like an edge.
module uart_frame_receiver_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {STAGES{RESET_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver: 8N1-style (configurable data bits, no parity, one stop
// bit) mid-bit sampling with start-bit glitch rejection, framing-error and
// overrun reporting.
//   sys_clk, rst : system clock, asynchronous active-high reset
//   bus.rx_in    : asynchronous serial line (idles high)
//   bus.rx_ack   : consumer accepts rx_data (only meaningful while rx_valid)
//   bus.rx_data  : last good word, LSB = first bit on the line
//   bus.rx_valid : rx_data holds an unconsumed word
//   bus.rx_frame_err / bus.rx_overrun : single-cycle error pulses
//   bus.rx_busy  : receiver is not idle
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int BIT_DURATION  = DEFAULT_BIT_DURATION,
  parameter int NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS
) (
  input logic                  sys_clk,
  input logic                  rst,
  uart_frame_receiver_if.master bus
);
  localparam int TIMER_W = $clog2(BIT_DURATION);
  localparam int CNT_W   = $clog2(NUM_DATA_BITS + 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(BIT_DURATION / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(BIT_DURATION - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(NUM_DATA_BITS - 1);

  logic                     rx_s;
  logic                     rx_prev;
  rx_state_t                state, state_n;
  logic [TIMER_W-1:0]       timer, timer_n;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_n;
  logic [NUM_DATA_BITS-1:0] shift, shift_n;
  logic                     good_stop, bad_stop;
  logic                     expired;

  uart_frame_receiver_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (bus.rx_in),
    .q   (rx_s)
  );

  assign expired = (timer == '0);

  // State register: FSM, bit timer, bit counter, shift register, edge history
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rx_prev <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Falling edge only; a line that is merely low does not start a frame.
        if (rx_prev && !rx_s) begin
          state_n   = ST_START;
          timer_n   = HALF_LOAD;
          bit_cnt_n = '0;
        end
      end
      ST_START: begin
        if (expired) begin
          // High at mid start bit: the edge was a glitch, drop it silently.
          if (rx_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            timer_n = FULL_LOAD;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_DATA: begin
        if (expired) begin
          shift_n   = {rx_s, shift[NUM_DATA_BITS-1:1]};
          timer_n   = FULL_LOAD;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = ST_STOP;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (expired) begin
          if (rx_s) begin
            good_stop = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_n  = ST_WAIT_HIGH;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output register: handshake, word hand-off and error pulses
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bus.rx_data      <= '0;
      bus.rx_valid     <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      bus.rx_overrun   <= 1'b0;
    end else begin
      bus.rx_frame_err <= bad_stop;
      // A same-cycle ack frees the slot, so the new word is not an overrun.
      bus.rx_overrun   <= good_stop && bus.rx_valid && !bus.rx_ack;
      if (good_stop && (!bus.rx_valid || bus.rx_ack)) begin
        bus.rx_data  <= shift;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_busy = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver: directed scenarios plus random frames, all
// checked against a frame-level model of the receiver's hand-off rules.
module tb_uart_frame_receiver;
  localparam int BD   = 104;
  localparam int NB   = 8;
  localparam int HALF = BD / 2;
  localparam int LAT  = 2 + BD / 2 + (NB + 1) * BD;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  uart_frame_receiver_if #(.NUM_DATA_BITS(NB)) bus ();

  uart_frame_receiver #(.BIT_DURATION(BD), .NUM_DATA_BITS(NB)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse counters and busy-gap measurement, sampled mid-cycle
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int idle_run = 0;
  int max_idle = 0;
  bit meas     = 1'b0;

  always @(negedge sys_clk) begin
    if (bus.rx_frame_err === 1'b1) ferr_cnt++;
    if (bus.rx_overrun === 1'b1) ovr_cnt++;
    if (!meas) begin
      idle_run = 0;
      max_idle = 0;
    end else if (bus.rx_busy !== 1'b1) begin
      idle_run++;
      if (idle_run > max_idle) max_idle = idle_run;
    end else begin
      idle_run = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Frame-level reference model
  logic [NB-1:0] m_data  = '0;
  bit            m_valid = 1'b0;
  int            m_ferr  = 0;
  int            m_ovr   = 0;

  function automatic void model_frame(input logic [NB-1:0] b);
    if (!m_valid) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr++;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge sys_clk);
    chk({tag, "_data"},  32'(bus.rx_data),  32'(m_data));
    chk({tag, "_valid"}, 32'(bus.rx_valid), 32'(m_valid));
    chk({tag, "_ferr"},  32'(ferr_cnt),     32'(m_ferr));
    chk({tag, "_ovr"},   32'(ovr_cnt),      32'(m_ovr));
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic align();
    @(posedge sys_clk);
    #1;
  endtask

  // Drives one frame; returns at the end of the stop bit with the line left at 'stop'.
  task automatic send_frame(input logic [NB-1:0] b, input logic stop);
    bus.rx_in = 1'b0;
    hold(BD);
    for (int i = 0; i < NB; i++) begin
      bus.rx_in = b[i];
      hold(BD);
    end
    bus.rx_in = stop;
    hold(BD);
  endtask

  task automatic ack_pulse();
    @(negedge sys_clk);
    bus.rx_ack = 1'b1;
    @(negedge sys_clk);
    bus.rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  logic [NB-1:0] got[$];
  logic [NB-1:0] rb;
  bit            ok;

  initial begin
    bus.rx_in  = 1'b1;
    bus.rx_ack = 1'b0;

    // Reset values
    #3;
    chk("rst_data",  32'(bus.rx_data),      32'h0);
    chk("rst_valid", 32'(bus.rx_valid),     32'h0);
    chk("rst_ferr",  32'(bus.rx_frame_err), 32'h0);
    chk("rst_ovr",   32'(bus.rx_overrun),   32'h0);
    chk("rst_busy",  32'(bus.rx_busy),      32'h0);
    hold(3);
    rst = 1'b0;
    hold(20);

    // Single frame, latency of rx_valid, then ack
    align();
    fork
      send_frame(8'h85, 1'b1);
      begin
        repeat (LAT) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("lat_before", 32'(bus.rx_valid), 32'h0);
        @(negedge sys_clk);
        chk("lat_at", 32'(bus.rx_valid), 32'h1);
      end
    join
    model_frame(8'h85);
    check_state("f85");
    ack_pulse();
    check_state("f85_ack");

    // Back-to-back frames, consumer acking as soon as each word appears
    got.delete();
    meas = 1'b1;
    fork
      begin
        send_frame(8'hF1, 1'b1);
        send_frame(8'h3D, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          ok = 1'b0;
          for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge sys_clk);
            if (bus.rx_valid === 1'b1) begin
              ok = 1'b1;
              break;
            end
          end
          chk("b2b_wait", 32'(ok), 32'h1);
          got.push_back(bus.rx_data);
          bus.rx_ack = 1'b1;
          @(negedge sys_clk);
          bus.rx_ack = 1'b0;
        end
      end
    join
    meas = 1'b0;
    model_frame(8'hF1);
    m_valid = 1'b0;
    model_frame(8'h3D);
    m_valid = 1'b0;
    chk("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("b2b_first",  32'(got[0]), 32'hF1);
      chk("b2b_second", 32'(got[1]), 32'h3D);
    end
    chk("b2b_gap_le", 32'(max_idle <= HALF + 2), 32'h1);
    check_state("b2b");

    // Start-bit glitch shorter than half a bit
    hold(10);
    bus.rx_in = 1'b0;
    hold(30);
    bus.rx_in = 1'b1;
    hold(2 * BD);
    chk("glitch_busy", 32'(bus.rx_busy), 32'h0);
    check_state("glitch");

    // Framing error with the line held low afterwards
    send_frame(8'h6E, 1'b0);
    hold(3 * BD);
    @(negedge sys_clk);
    chk("ferr_hold_busy", 32'(bus.rx_busy), 32'h1);
    m_ferr++;
    check_state("ferr_hold");
    bus.rx_in = 1'b1;
    hold(BD);
    chk("ferr_release_busy", 32'(bus.rx_busy), 32'h0);
    check_state("ferr_release");
    send_frame(8'h91, 1'b1);
    model_frame(8'h91);
    check_state("f91");
    ack_pulse();

    // Overrun: unacked word, then a second frame
    hold(5);
    send_frame(8'h0B, 1'b1);
    model_frame(8'h0B);
    check_state("f0b");
    hold(7);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22);
    check_state("ovr");

    // Ack exactly in the stop-bit sample cycle of the next frame
    align();
    fork
      send_frame(8'h47, 1'b1);
      begin
        repeat (LAT - 1) @(posedge sys_clk);
        #1;
        bus.rx_ack = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.rx_ack = 1'b0;
      end
    join
    m_valid = 1'b0;
    model_frame(8'h47);
    check_state("coinc");
    ack_pulse();
    check_state("coinc_ack");

    // Reset in the middle of a frame, with an unconsumed word pending
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C);
    check_state("pre_rst");
    align();
    fork
      send_frame(8'h55, 1'b1);
      begin
        hold(150);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data",  32'(bus.rx_data),      32'h0);
        chk("arst_valid", 32'(bus.rx_valid),     32'h0);
        chk("arst_busy",  32'(bus.rx_busy),      32'h0);
        chk("arst_ferr",  32'(bus.rx_frame_err), 32'h0);
        chk("arst_ovr",   32'(bus.rx_overrun),   32'h0);
      end
    join
    m_data  = '0;
    m_valid = 1'b0;
    hold(5);
    rst = 1'b0;
    hold(BD);
    check_state("post_rst");
    send_frame(8'hAA, 1'b1);
    model_frame(8'hAA);
    check_state("faa");
    ack_pulse();

    // Random frames with random gaps and random consumer behaviour
    for (int n = 0; n < 8; n++) begin
      hold($urandom_range(0, 40));
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
      model_frame(rb);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        check_state("rand_ack");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
